// File: rtl/half_band_dec_mc.sv
// Multi-channel half-band FIR (-1,0,9,16,9,0,-1)/16 with 2:1 decimation on a channel-interleaved stream.
// Optional sticky saturation flag output enabled by defining HALF_BAND_DEC_SAT_FLAG_EN.
module half_band_dec_mc #(
    parameter int DW  = 16,
    parameter int NCH = 2,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_first,
    output logic [DW:0]   dout,
    output logic          dout_valid,
    output logic [CW-1:0] dout_ch
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
    ,
    output logic          sat_flag
`endif
);

    localparam int AW  = DW + 6;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]        LAST_CH = CW'(NCH - 1);
    localparam logic signed [AW-1:0] Y_MAX   = AW'((2 ** DW) - 1);
    localparam logic signed [AW-1:0] Y_MIN   = -Y_MAX - 1;

    function automatic logic signed [AW-1:0] sext(input logic [DW-1:0] v);
        return {{(AW - DW){v[DW-1]}}, v};
    endfunction

    logic [CW-1:0]  ch_cnt;
    logic [CW-1:0]  ch_sel;
    logic [CHW-1:0] ch_idx;
    logic           phase;
    logic           wrap;

    // din itself is x[n]; the array holds x[n-1]..x[n-6] per channel.
    logic signed [DW-1:0] hist [NCH][6];

    logic                 v1, v2, v3, v4;
    logic [CW-1:0]        c1, c2, c3, c4;
    logic signed [AW-1:0] s1_a, s1_b, s1_c;
    logic signed [AW-1:0] s2_a8, s2_b9, s2_c16;
    logic signed [AW-1:0] s3_acc;
    logic signed [AW-1:0] y_full;
    logic [DW:0]          y_sat;
    logic                 y_is_sat;
    logic [DW:0]          s4_y;
    logic                 s4_sat;

    assign ch_sel = din_first ? '0 : ch_cnt;
    assign ch_idx = ch_sel[CHW-1:0];
    assign wrap   = (ch_sel == LAST_CH);

    // A resync sample is channel 0 and never the last channel, so phase only moves on a real wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt <= '0;
            phase  <= 1'b0;
        end else if (din_valid) begin
            ch_cnt <= wrap ? '0 : ch_sel + CW'(1);
            if (wrap) begin
                phase <= ~phase;
            end
        end
    end

    // NOTE: history must restart from zero after rst, so the storage carries a reset and maps to flops, not RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < 6; k++) begin
                    hist[c][k] <= '0;
                end
            end
        end else if (din_valid) begin
            hist[ch_idx][0] <= din;
            for (int k = 1; k < 6; k++) begin
                hist[ch_idx][k] <= hist[ch_idx][k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            v1 <= din_valid & phase;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
        end
    end

    // NOTE: datapath registers carry no reset; the valid chain alone decides what reaches dout.
    always_ff @(posedge clk) begin
        c1     <= ch_sel;
        s1_a   <= -sext(din) - sext(hist[ch_idx][5]);
        s1_b   <= sext(hist[ch_idx][1]) + sext(hist[ch_idx][3]);
        s1_c   <= sext(hist[ch_idx][2]);
        c2     <= c1;
        s2_a8  <= s1_a + AW'(8);
        s2_b9  <= (s1_b <<< 3) + s1_b;
        s2_c16 <= s1_c <<< 4;
        c3     <= c2;
        s3_acc <= s2_a8 + s2_b9 + s2_c16;
        c4     <= c3;
        s4_y   <= y_sat;
        s4_sat <= y_is_sat;
    end

    always_comb begin
        y_full   = s3_acc >>> 4;
        y_sat    = y_full[DW:0];
        y_is_sat = 1'b0;
        if (y_full > Y_MAX) begin
            y_sat    = Y_MAX[DW:0];
            y_is_sat = 1'b1;
        end else if (y_full < Y_MIN) begin
            y_sat    = Y_MIN[DW:0];
            y_is_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
        end else begin
            dout_valid <= v4;
            if (v4) begin
                dout    <= s4_y;
                dout_ch <= c4;
            end
        end
    end

`ifdef HALF_BAND_DEC_SAT_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (v4 && s4_sat) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_half_band_dec_mc.sv
// Scoreboard bench: one single-channel and one four-channel instance, directed vectors.
module tb_half_band_dec_mc;

    typedef struct {
        int  val;
        int  ch;
        time t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] din1 = '0, din4 = '0;
    logic        din_valid1 = 1'b0, din_valid4 = 1'b0;
    logic        din_first1 = 1'b0, din_first4 = 1'b0;
    logic [16:0] dout1, dout4;
    logic        dout_valid1, dout_valid4;
    logic [2:0]  dout_ch1, dout_ch4;
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
    logic        sat_flag1, sat_flag4;
`endif

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    int   n_pass  = 0;
    int   n_total = 0;

    int imp_exp [6] = '{-62, 563, 563, -62, 0, 0};
    int dc_exp  [8] = '{-62, 1500, 2063, 2000, 2000, 2000, 2000, 2000};
    int sat_seq [8] = '{0, -32768, 0, 32767, 32767, 32767, 0, -32768};
    int sat_exp [4] = '{2048, -20480, -2048, 65535};

    always #5 clk = ~clk;

    half_band_dec_mc #(.DW(16), .NCH(1), .CW(3)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din1),
        .din_valid  (din_valid1),
        .din_first  (din_first1),
        .dout       (dout1),
        .dout_valid (dout_valid1),
        .dout_ch    (dout_ch1)
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
        ,
        .sat_flag   (sat_flag1)
`endif
    );

    half_band_dec_mc #(.DW(16), .NCH(4), .CW(3)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din4),
        .din_valid  (din_valid4),
        .din_first  (din_first4),
        .dout       (dout4),
        .dout_valid (dout_valid4),
        .dout_ch    (dout_ch4)
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
        ,
        .sat_flag   (sat_flag4)
`endif
    );

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitors: pop one expectation per strobe, including the cycle it was due.
    always @(negedge clk) begin
        if (dout_valid1) begin
            check("dut1_expected_output", q1.size() > 0, q1.size(), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("dut1_dout", $signed(dout1) == e1.val, int'($signed(dout1)), e1.val);
                check("dut1_ch", int'(dout_ch1) == e1.ch, int'(dout_ch1), e1.ch);
                check("dut1_latency", ($time - 5) == e1.t, int'($time - 5), int'(e1.t));
            end
        end
    end

    always @(negedge clk) begin
        if (dout_valid4) begin
            check("dut4_expected_output", q4.size() > 0, q4.size(), 1);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                check("dut4_dout", $signed(dout4) == e4.val, int'($signed(dout4)), e4.val);
                check("dut4_ch", int'(dout_ch4) == e4.ch, int'(dout_ch4), e4.ch);
                check("dut4_latency", ($time - 5) == e4.t, int'($time - 5), int'(e4.t));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send1(input int v, input bit ev, input int ex);
        din1       = v[15:0];
        din_valid1 = 1'b1;
        din_first1 = 1'b0;
        @(posedge clk);
        if (ev) q1.push_back('{val: ex, ch: 0, t: $time + 40});
        @(negedge clk);
        din_valid1 = 1'b0;
    endtask

    task automatic send4(input int v, input bit first, input bit ev, input int ex,
                         input int ch, input int gap);
        din4       = v[15:0];
        din_valid4 = 1'b1;
        din_first4 = first;
        @(posedge clk);
        if (ev) q4.push_back('{val: ex, ch: ch, t: $time + 40});
        @(negedge clk);
        din_valid4 = 1'b0;
        din_first4 = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && (q1.size() > 0 || q4.size() > 0); i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({name, "_drain1"}, q1.size() == 0, q1.size(), 0);
        check({name, "_drain4"}, q4.size() == 0, q4.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_dout1"}, dout1 == 17'd0, int'(dout1), 0);
        check({name, "_valid1"}, dout_valid1 == 1'b0, int'(dout_valid1), 0);
        check({name, "_ch1"}, dout_ch1 == 3'd0, int'(dout_ch1), 0);
        check({name, "_dout4"}, dout4 == 17'd0, int'(dout4), 0);
        check({name, "_valid4"}, dout_valid4 == 1'b0, int'(dout_valid4), 0);
        check({name, "_ch4"}, dout_ch4 == 3'd0, int'(dout_ch4), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, c;

        do_reset();
        check_idle("reset");
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
        check("reset_sat_flag1", sat_flag1 == 1'b0, int'(sat_flag1), 0);
`endif

        // Impulse in frame 1; outputs on odd samples only.
        for (int s = 0; s < 12; s++)
            send1((s == 1) ? 1000 : 0, s % 2 == 1, (s % 2 == 1) ? imp_exp[s / 2] : 0);
        drain("impulse");

        // DC input settles to gain 2 once the history is full.
        do_reset();
        for (int s = 0; s < 16; s++)
            send1(1000, s % 2 == 1, (s % 2 == 1) ? dc_exp[s / 2] : 0);
        drain("dc");

        // Positive full-scale saturation.
        do_reset();
        for (int s = 0; s < 8; s++)
            send1(sat_seq[s], s % 2 == 1, (s % 2 == 1) ? sat_exp[s / 2] : 0);
        drain("sat");
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
        check("sat_flag1_set", sat_flag1 == 1'b1, int'(sat_flag1), 1);
`endif

        // Four channels, one sample every third cycle, constant per channel.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 4; k++) begin
                v = 100 * (k + 1);
                c = (f == 1) ? -1 : (f == 3) ? 24 : (f == 5) ? 33 : 32;
                send4(v, k == 0, f % 2 == 1, (c * v + 8) >>> 4, k, 3);
            end
        end
        drain("multi");
        check("hold_dout4", $signed(dout4) == 800, int'($signed(dout4)), 800);
        check("hold_ch4", dout_ch4 == 3'd3, int'(dout_ch4), 3);
        check("hold_valid4", dout_valid4 == 1'b0, int'(dout_valid4), 0);

        // Resync on the third sample of frame 0: phase stays 0, history kept.
        do_reset();
        send4(100, 1'b1, 1'b0, 0, 0, 1);
        send4(200, 1'b0, 1'b0, 0, 0, 1);
        send4(100, 1'b1, 1'b0, 0, 0, 1);
        send4(200, 1'b0, 1'b0, 0, 0, 1);
        send4(300, 1'b0, 1'b0, 0, 0, 1);
        send4(400, 1'b0, 1'b0, 0, 0, 1);
        send4(100, 1'b1, 1'b1, 50, 0, 1);
        send4(200, 1'b0, 1'b1, 100, 1, 1);
        send4(300, 1'b0, 1'b1, -19, 2, 1);
        send4(400, 1'b0, 1'b1, -25, 3, 1);
        drain("resync");

        // Reset two cycles after a phase-1 sample: its result must vanish.
        do_reset();
        send1(0, 1'b0, 0);
        send1(1000, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
`ifdef HALF_BAND_DEC_SAT_FLAG_EN
        check("midrst_sat_flag1", sat_flag1 == 1'b0, int'(sat_flag1), 0);
`endif
        repeat (6) @(negedge clk);
        send1(500, 1'b0, 0);
        send1(500, 1'b1, -31);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/half_band_dec_mc.md
Name: half_band_dec_mc

Overview:
Parametrised multi-channel half-band filter and 2:1 decimator. Filters a channel-interleaved sample stream with taps -1, 0, 9, 16, 9, 0, -1 (scaled 1/16, DC gain 2). Emits one decimated output per channel for every two input frames. Sits after the mixer/CIC stage in the receive chain.
- Generalises the fixed two-channel, clk/4-phased half-band to arbitrary width, channel count and sample rate via a valid strobe.

Parameters:
DW, 16, input sample width (signed), 8..24
NCH, 2, number of interleaved channels, 1..8
CW, 3, channel index width; must satisfy 2**CW >= NCH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
din  in  DW  signed input sample
din_valid  in  1  din accepted this cycle
din_first  in  1  qualifies din as channel 0 (frame start); ignored unless din_valid
dout  out  DW+1  signed filtered, decimated sample
dout_valid  out  1  one-cycle strobe, dout/dout_ch valid
dout_ch  out  CW  channel index of dout

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset: clears all history to 0, channel counter to 0 and frame phase to 0. dout=0, dout_valid=0, dout_ch=0. An in-flight pipeline result is discarded and no dout_valid follows.
- Channel counter: increments on each accepted sample and wraps NCH-1 -> 0. Frame phase toggles on the wrap.
- din_valid with din_first forces the current sample to channel 0.
  - If the counter was nonzero: resync. The partial frame is abandoned, phase is unchanged, history is not cleared.
- Per channel, keep the last 7 accepted samples x[n]..x[n-6]. Storage is NCH*7*DW bits; registers or distributed RAM.
- History updates on every accepted sample regardless of phase.
- Output is computed only for samples accepted while phase=1, i.e. frames 1, 3, 5, ... after reset:
  - acc = -x[n] + 9x[n-2] + 16x[n-3] + 9x[n-4] - x[n-6] + 8, held at full precision in DW+6 bits.
  - y = acc >>> 4 (arithmetic, floor).
  - y saturates to DW+1 bits: +2**DW-1 or -2**DW.
- Latency: exactly 4 clk from the accepting edge to the dout_valid edge. It is fixed and independent of din_valid gaps. dout_ch equals the channel of the accepted sample.
- Throughput: din_valid may be high every cycle; the pipeline is fully pipelined with no stall or backpressure. Arbitrary gaps are allowed.
- dout holds its last value between strobes. dout_valid is never high for two results of the same channel without an intervening frame.

Optional Feature:
Macro HALF_BAND_DEC_SAT_FLAG_EN.
- Defined: adds output port sat_flag (1 bit), a sticky flag. It is set the cycle dout_valid presents a saturated value. It is cleared only by rst.
- Undefined: the port is absent and the saturation logic is otherwise identical.

Test Plan:
1. NCH=1, DW=16, impulse din=1000 at sample 0 of frame 1, else 0 -> outputs at odd samples -62, 563, 563, -62, then 0; each 4 clk after the accepting edge.
2. NCH=1, DC din=1000 continuously -> after the 7-sample fill, every output is 2000. No dout_valid during frame 0.
3. NCH=1, sequence with x[n]=x[n-6]=-32768 and x[n-2..n-4]=32767 -> dout=65535 (saturated); sat_flag=1 when enabled.
4. NCH=4, din_valid every 3rd cycle, channel k constant 100*(k+1), din_first on channel 0 -> steady outputs 200, 400, 600, 800 with dout_ch 0, 1, 2, 3 on odd frames only.
5. NCH=4, din_first asserted on the 3rd sample of a frame -> that sample is treated as ch0, the next as ch1, and phase is unchanged.
6. rst pulsed 2 clk after a phase-1 sample is accepted -> no dout_valid for that sample, all outputs 0, and the first subsequent output appears in frame 1 after reset.
